// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_arbiter
// Description : Round-robin arbiter that lets two requesters share one
//               combinational logic unit (AND/OR/XOR/NOR). A granted request
//               is held on the unit for SETTLE cycles, and then the result
//               is returned through a valid/ready response port.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_op0,
    input  logic [1:0]       req_op1,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [WIDTH-1:0] lu_a,
    output logic [WIDTH-1:0] lu_b,
    output logic [1:0]       lu_op,
    input  logic [WIDTH-1:0] lu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] C_SETTLE_M1 = 4'(SETTLE - 1);

    state_e           state_q;
    logic             last_q;       // last granted requester; doubles as the owner id
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             rsp_valid_q;
    logic             busy_q;

    logic             grant_id_w;
    logic [1:0]       grant_op_w;
    logic [WIDTH-1:0] grant_a_w;
    logic [WIDTH-1:0] grant_b_w;

    // Round-robin pick: the sole valid requester wins; on contention the one not granted last wins.
    always_comb begin
        grant_id_w = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        grant_op_w = grant_id_w ? req_op1 : req_op0;
        grant_a_w  = grant_id_w ? req_a1  : req_a0;
        grant_b_w  = grant_id_w ? req_b1  : req_b0;
        req_ready  = 2'b00;
        // Gated by rst_n so that no accept is advertised while reset is held.
        if (rst_n && (state_q == IDLE) && (req_valid != 2'b00)) begin
            req_ready = grant_id_w ? 2'b10 : 2'b01;
        end
    end

    // Shared-unit operands are only presented while an operation is in flight.
    always_comb begin
        lu_a  = '0;
        lu_b  = '0;
        lu_op = 2'b00;
        if (state_q != IDLE) begin
            lu_a  = a_q;
            lu_b  = b_q;
            lu_op = op_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

    // Control FSM: accept in IDLE, hold operands for SETTLE cycles in EXEC, hand off in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            op_q        <= 2'b00;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= 4'd0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid != 2'b00) begin
                        op_q    <= grant_op_w;
                        a_q     <= grant_a_w;
                        b_q     <= grant_b_w;
                        last_q  <= grant_id_w;
                        cnt_q   <= C_SETTLE_M1;
                        busy_q  <= 1'b1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == 4'd0) begin
                        rsp_data_q  <= lu_result;
                        rsp_id_q    <= last_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_arbiter
// Description : Scoreboard bench for logic_unit_arbiter. One instance runs
//               with SETTLE=1 and a behavioural logic unit; a second runs
//               with SETTLE=4 and a bench-driven unit result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // SETTLE=1 instance
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_op0 = 2'b00, req_op1 = 2'b00;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [31:0] lu_a, lu_b, lu_result;
    logic [1:0]  lu_op;
    logic        rsp_valid, rsp_id, busy;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_data;

    // SETTLE=4 instance
    logic [1:0]  s_req_valid = 2'b00;
    logic [1:0]  s_req_ready;
    logic [1:0]  s_op0 = 2'b00, s_op1 = 2'b00;
    logic [31:0] s_a0 = '0, s_b0 = '0, s_a1 = '0, s_b1 = '0;
    logic [31:0] s_lu_a, s_lu_b;
    logic [31:0] s_lu_result = '0;
    logic [1:0]  s_lu_op;
    logic        s_rsp_valid, s_rsp_id, s_busy;
    logic        s_rsp_ready = 1'b0;
    logic [31:0] s_rsp_data;

    typedef struct {
        logic        id;
        logic [1:0]  op;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic grant_log[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    logic_unit_arbiter #(.WIDTH(32), .SETTLE(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_result(lu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy)
    );

    logic_unit_arbiter #(.WIDTH(32), .SETTLE(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_op0(s_op0), .req_op1(s_op1),
        .req_a0(s_a0), .req_b0(s_b0), .req_a1(s_a1), .req_b1(s_b1),
        .lu_a(s_lu_a), .lu_b(s_lu_b), .lu_op(s_lu_op), .lu_result(s_lu_result),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready),
        .rsp_data(s_rsp_data), .rsp_id(s_rsp_id), .busy(s_busy)
    );

    // Behavioural shared logic unit
    always_comb begin
        case (lu_op)
            2'b00:   lu_result = lu_a & lu_b;
            2'b01:   lu_result = lu_a | lu_b;
            2'b10:   lu_result = lu_a ^ lu_b;
            default: lu_result = ~(lu_a | lu_b);
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Drive one request, wait for its grant, and record the expected response.
    task automatic issue(input logic id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] want);
        bit ok = 0;
        if (id) begin req_op1 = op; req_a1 = a; req_b1 = b; end
        else    begin req_op0 = op; req_a0 = a; req_b0 = b; end
        req_valid[id] = 1'b1;
        for (int c = 0; c < 100 && !ok; c++) begin
            #1;
            if (req_ready[id]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL grant_timeout: requester %0d got no req_ready, expected grant", id);
            req_valid[id] = 1'b0;
        end else begin
            exp_q.push_back('{id: id, op: op, data: want});
            grant_log.push_back(id);
            @(posedge clk);
            @(negedge clk);
            req_valid[id] = 1'b0;
        end
    endtask

    // Monitor: pop and compare whenever a response handshake is about to occur.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got rsp_id %0d data %h, expected no response", rsp_id, rsp_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
                chk("lu_op", {30'd0, lu_op}, {30'd0, e.op});
            end
        end
    end

    initial begin
        // ---------------- reset state ----------------
        req_valid = 2'b11;
        #12;
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_lu_a_b", lu_a | lu_b, 32'd0);
        chk("rst_lu_op", {30'd0, lu_op}, 32'd0);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- contention: grants 0,1,0,1 ----------------
        fork
            begin
                issue(1'b0, 2'b00, 32'h0000_FFFF, 32'h0F0F_0F0F, 32'h0000_0F0F);
                issue(1'b0, 2'b10, 32'h1234_5678, 32'hFFFF_0000, 32'hEDCB_5678);
            end
            begin
                issue(1'b1, 2'b01, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF);
                issue(1'b1, 2'b11, 32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_000F);
            end
        join
        chk("contention_grants", {28'd0, grant_log[0], grant_log[1], grant_log[2], grant_log[3]}, 32'b0101);

        // ---------------- single request, SETTLE=1 ----------------
        @(negedge clk);
        issue(1'b0, 2'b01, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        chk("single_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("single_exec_busy", {31'd0, busy}, 32'd1);
        chk("single_exec_lu_a", lu_a, 32'hF0F0_0000);
        @(negedge clk);
        #1;
        chk("single_resp_rsp_valid", {31'd0, rsp_valid}, 32'd1);

        // ---------------- op coverage ----------------
        @(negedge clk);
        issue(1'b1, 2'b00, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'h8888_8888);
        issue(1'b1, 2'b01, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'hEEEE_EEEE);
        issue(1'b1, 2'b10, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'h6666_6666);
        issue(1'b1, 2'b11, 32'hAAAA_AAAA, 32'hCCCC_CCCC, 32'h1111_1111);

        // ---------------- backpressure ----------------
        @(negedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        issue(1'b0, 2'b10, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FF0_0FF0);
        fork
            issue(1'b1, 2'b00, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_0000);
        join_none
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #2;
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", rsp_data, 32'h0FF0_0FF0);
            chk("bp_rsp_id", {31'd0, rsp_id}, 32'd0);
            chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
            chk("bp_busy", {31'd0, busy}, 32'd1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("bp_pending_accept", {30'd0, req_ready}, 32'b10);
        wait fork;

        // ---------------- reset mid-EXEC ----------------
        @(negedge clk);
        @(negedge clk);
        req_op0 = 2'b01; req_a0 = 32'h5555_0000; req_b0 = 32'h0000_5555;
        req_valid = 2'b01;
        #1;
        chk("abort_req_ready", {30'd0, req_ready}, 32'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        chk("abort_rsp_id", {31'd0, rsp_id}, 32'd0);
        chk("abort_lu", lu_a | lu_b | {30'd0, lu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        grant_log.delete();
        fork
            issue(1'b0, 2'b00, 32'hFF00_FF00, 32'hF0F0_F0F0, 32'hF000_F000);
            issue(1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000);
        join
        chk("post_reset_grants", {30'd0, grant_log[0], grant_log[1]}, 32'b01);

        // ---------------- settle timing, SETTLE=4 ----------------
        @(negedge clk);
        s_op0 = 2'b10; s_a0 = 32'h1111_2222; s_b0 = 32'h3333_4444;
        s_lu_result = 32'hDEAD_BEEF;
        s_req_valid = 2'b01;
        #1;
        chk("s4_req_ready", {30'd0, s_req_ready}, 32'b01);
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) s_req_valid = 2'b00;
            if (k == 3) s_lu_result = 32'hC0DE_1234;
            #2;
            if (k <= 4) begin
                chk("s4_exec_rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
                chk("s4_exec_lu_op", {30'd0, s_lu_op}, 32'b10);
            end else begin
                chk("s4_resp_rsp_valid", {31'd0, s_rsp_valid}, 32'd1);
                chk("s4_resp_rsp_data", s_rsp_data, 32'hC0DE_1234);
                chk("s4_resp_rsp_id", {31'd0, s_rsp_id}, 32'd0);
            end
        end
        s_rsp_ready = 1'b1;
        @(negedge clk);
        #2;
        chk("s4_idle_busy", {31'd0, s_busy}, 32'd0);

        // ---------------- drain ----------------
        for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
